// File: rtl/common_valid_elastic_buffer.sv
// common_valid_elastic_buffer
// Elastic FIFO that sits after a valid-gated delay line which cannot be stalled.
// The head word is presented first-word-fall-through. A write into an empty
// buffer reaches the output one cycle later because there is no bypass path.
// Writes that arrive while the buffer is full, with no read in the same cycle,
// are dropped. o_overflow records any such drop and stays set until reset.
//
// Optional feature: define COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN to add
// o_ovf_count. It is a 16-bit saturating count of dropped writes.
//
// Handshake: a read happens on a rising edge where o_valid && i_ready.
// A write happens where i_valid && (!full || read). The upstream side has no
// ready signal, so it must throttle i_valid using o_afull.
module common_valid_elastic_buffer #(
  parameter int NB_DATA    = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int AFULL_THR  = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_DATA-1:0]    i_data_in,
  input  logic                  i_valid,
  input  logic                  i_ready,
  output logic [NB_DATA-1:0]    o_data_out,
  output logic                  o_valid,
  output logic                  o_afull,
  output logic [LOG2_DEPTH:0]   o_level,
  output logic                  o_overflow
`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
  ,
  output logic [15:0]           o_ovf_count
`endif
);

  localparam int                DEPTH   = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] AFULL_L = (LOG2_DEPTH + 1)'(AFULL_THR);

  logic [NB_DATA-1:0]  mem [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr;
  logic [LOG2_DEPTH:0] rd_ptr;
  logic [LOG2_DEPTH:0] wr_ptr_nxt;
  logic [LOG2_DEPTH:0] rd_ptr_nxt;
  logic [LOG2_DEPTH:0] level_q;
  logic                overflow_q;
  logic                empty;
  logic                full;
  logic                rd_en;
  logic                wr_en;
  logic                drop;

  // Full and empty come from the pointers. Full means the addresses match and
  // the wrap bits differ.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]) &&
                 (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]);

  // Decide the events for this cycle. A read in the same cycle frees a slot,
  // so a write is still accepted when the buffer is full.
  always_comb begin
    rd_en      = !empty && i_ready;
    wr_en      = i_valid && (!full || rd_en);
    drop       = i_valid && full && !rd_en;
    wr_ptr_nxt = wr_ptr + (LOG2_DEPTH + 1)'(wr_en);
    rd_ptr_nxt = rd_ptr + (LOG2_DEPTH + 1)'(rd_en);
  end

  // Pointers, registered level and the sticky overflow flag.
  // Reset takes priority over any read or write in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      level_q    <= wr_ptr_nxt - rd_ptr_nxt;
      overflow_q <= overflow_q | drop;
    end
  end

  // Storage is cleared on reset, so the output word reads 0 after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr[LOG2_DEPTH-1:0]] <= i_data_in;
    end
  end

`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Count dropped writes. The counter saturates at all-ones.
  always_ff @(posedge i_clock) begin
    if (i_reset)                       ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign o_ovf_count = ovf_cnt_q;
`endif

  assign o_data_out = mem[rd_ptr[LOG2_DEPTH-1:0]];
  assign o_valid    = !empty;
  assign o_level    = level_q;
  assign o_afull    = (level_q >= AFULL_L);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_common_valid_elastic_buffer.sv
// Testbench for common_valid_elastic_buffer.
// The reference model is a queue of words plus an overflow flag and a drop count.
module tb_common_valid_elastic_buffer;

  localparam int NB_DATA    = 8;
  localparam int LOG2_DEPTH = 3;
  localparam int AFULL_THR  = 6;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  // ---------------- clock / reset ----------------
  logic                i_clock = 1'b0;
  logic                i_reset = 1'b1;
  logic [NB_DATA-1:0]  i_data_in = '0;
  logic                i_valid = 1'b0;
  logic                i_ready = 1'b0;
  logic [NB_DATA-1:0]  o_data_out;
  logic                o_valid;
  logic                o_afull;
  logic [LOG2_DEPTH:0] o_level;
  logic                o_overflow;
`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
  logic [15:0]         o_ovf_count;
`endif

  always #5 i_clock = ~i_clock;

  common_valid_elastic_buffer #(
    .NB_DATA(NB_DATA), .LOG2_DEPTH(LOG2_DEPTH), .AFULL_THR(AFULL_THR)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_data_in(i_data_in),
    .i_valid(i_valid), .i_ready(i_ready), .o_data_out(o_data_out),
    .o_valid(o_valid), .o_afull(o_afull), .o_level(o_level),
    .o_overflow(o_overflow)
`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
    , .o_ovf_count(o_ovf_count)
`endif
  );

  // ---------------- scoreboard / model ----------------
  logic [NB_DATA-1:0] exp_q[$];
  bit                 m_ovf = 0;
  int                 m_ovf_cnt = 0;
  int                 errors = 0;
  int                 checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model. The head word is checked only
  // when the model holds at least one word.
  task automatic check_all(input string tag);
    chk({tag, ".valid"},    32'(o_valid),    32'(exp_q.size() > 0));
    chk({tag, ".level"},    32'(o_level),    32'(exp_q.size()));
    chk({tag, ".afull"},    32'(o_afull),    32'(exp_q.size() >= AFULL_THR));
    chk({tag, ".overflow"}, 32'(o_overflow), 32'(m_ovf));
    if (exp_q.size() > 0) chk({tag, ".data"}, 32'(o_data_out), 32'(exp_q[0]));
`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
    chk({tag, ".ovf_count"}, 32'(o_ovf_count), 32'(m_ovf_cnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Check the current outputs, drive one cycle, then update the model.
  // The task is entered 1 time unit after a rising edge.
  task automatic step(input string tag, input bit v, input logic [NB_DATA-1:0] d, input bit r);
    bit rd, wr;
    check_all(tag);
    i_valid   = v;
    i_data_in = d;
    i_ready   = r;
    rd = (exp_q.size() > 0) && r;
    wr = v && ((exp_q.size() < DEPTH) || rd);
    @(posedge i_clock);
    #1;
    if (rd) void'(exp_q.pop_front());
    if (wr) exp_q.push_back(d);
    if (v && !wr) begin
      m_ovf = 1;
      if (m_ovf_cnt < 65535) m_ovf_cnt++;
    end
  endtask

  // Reset for one cycle while driving the given valid/ready values, then
  // check the cleared state.
  task automatic do_reset(input bit v, input bit r);
    i_reset   = 1'b1;
    i_valid   = v;
    i_ready   = r;
    i_data_in = 8'hEE;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    exp_q.delete();
    m_ovf     = 0;
    m_ovf_cnt = 0;
    check_all("reset");
    chk("reset.data0", 32'(o_data_out), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NB_DATA-1:0] d;
    bit v;
    bit r;
    @(posedge i_clock);
    #1;
    do_reset(1'b0, 1'b0);

    // Single write with i_ready high: the word appears one cycle later and is
    // gone the cycle after that.
    step("single.w", 1, 8'hA5, 1);
    chk("single.c1_valid", 32'(o_valid),    32'h1);
    chk("single.c1_data",  32'(o_data_out), 32'hA5);
    step("single.r", 0, 8'h00, 1);
    chk("single.c2_valid", 32'(o_valid), 32'h0);
    chk("single.c2_level", 32'(o_level), 32'h0);

    // Fill with 0x01..0x08 and i_ready low, then write once more to force a drop.
    do_reset(0, 0);
    for (int i = 1; i <= 8; i++) step("fill", 1, 8'(i), 0);
    chk("fill.level", 32'(o_level), 32'd8);
    chk("fill.afull", 32'(o_afull), 32'h1);
    step("drop", 1, 8'h09, 0);
    chk("drop.overflow", 32'(o_overflow), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.order", 32'(o_data_out), 32'(i));
      step("drain", 0, 8'h00, 1);
    end
    chk("drain.empty", 32'(o_valid), 32'h0);

    // Full buffer with write and read in the same cycle for 20 cycles.
    // The level holds and the data stays in order across the pointer wrap.
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) step("pt.fill", 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++) step("pt", 1, 8'(8'h18 + i), 1);
    chk("pt.level", 32'(o_level), 32'd8);
    chk("pt.ovf",   32'(o_overflow), 32'h0);
    for (int i = 0; i < 8; i++) step("pt.drain", 0, 8'h00, 1);

    // Reset at level 4 while a read and a write are both requested.
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) step("l4", 1, 8'(8'h40 + i), 0);
    do_reset(1, 1);
    step("post.w", 1, 8'h3C, 0);
    chk("post.first", 32'(o_data_out), 32'h3C);
    step("post.r", 0, 8'h00, 1);

`ifdef COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN
    // Keep dropping writes until the counter saturates.
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) step("sat.fill", 1, 8'(8'h80 + i), 0);
    for (int i = 0; i < 70000; i++) step("sat", 1, 8'h55, 0);
    chk("sat.count", 32'(o_ovf_count), 32'hFFFF);
    for (int i = 0; i < 8; i++) step("sat.drain", 0, 8'h00, 1);
`endif

    // Random traffic. Writes are gated by the model's almost-full state, so no
    // write is ever dropped.
    do_reset(0, 0);
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0) && (exp_q.size() < AFULL_THR);
      r = ($urandom_range(0, 2) != 0);
      d = 8'($urandom);
      step("rand", v, d, r);
    end
    chk("rand.ovf", 32'(o_overflow), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/common_valid_elastic_buffer.md
COMMON_VALID_ELASTIC_BUFFER -- requirements
Module: common_valid_elastic_buffer

Interface
REQ-001 Parameter NB_DATA, default 8, data word width in bits.
REQ-002 Parameter LOG2_DEPTH, default 3, buffer depth = 2**LOG2_DEPTH words; legal range 1..8.
REQ-003 Parameter AFULL_THR, default 6, occupancy at or above which o_afull asserts; legal range 1..2**LOG2_DEPTH.
REQ-004 i_clock  input  1  clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_data_in  input  NB_DATA  write word from the upstream valid-gated delay line.
REQ-007 i_valid  input  1  write qualifier; upstream has no backpressure input.
REQ-008 i_ready  input  1  downstream consumer accepts the head word this cycle.
REQ-009 o_data_out  output  NB_DATA  head word, first-word-fall-through.
REQ-010 o_valid  output  1  head word present (buffer not empty).
REQ-011 o_afull  output  1  occupancy >= AFULL_THR; upstream throttles i_valid on it.
REQ-012 o_level  output  LOG2_DEPTH+1  current occupancy, 0..2**LOG2_DEPTH.
REQ-013 o_overflow  output  1  sticky flag: at least one write dropped since reset.

Function
REQ-014 Read event SHALL occur when o_valid and i_ready are both 1; rd pointer advances by one.
REQ-015 Write event SHALL occur when i_valid=1 and (level < 2**LOG2_DEPTH or a read event occurs the same cycle); word stored at wr pointer, wr pointer advances by one.
REQ-016 Simultaneous write and read while full SHALL both be accepted; level unchanged.
REQ-017 Simultaneous write and read while non-empty and non-full SHALL leave level unchanged.
REQ-018 No empty bypass: a word written into an empty buffer at edge N SHALL appear with o_valid=1 at cycle N+1 (write-to-output latency 1 cycle).
REQ-019 i_ready while o_valid=0 SHALL have no effect.
REQ-020 i_valid=1 while full with no read event SHALL drop i_data_in, leave buffer contents and pointers unchanged, and set o_overflow=1 from the next cycle until reset.
REQ-021 Pointers SHALL be LOG2_DEPTH+1 bits with wrap bit; full = address bits equal and wrap bits differ; empty = pointers equal; wrap-around from last to first entry SHALL be seamless.
REQ-022 o_level SHALL equal wr pointer minus rd pointer modulo 2**(LOG2_DEPTH+1), registered, consistent with o_valid in the same cycle.
REQ-023 o_afull SHALL be derived from the registered o_level (no extra latency beyond o_level).
REQ-024 o_data_out SHALL drive storage at rd pointer; words leave in write order, none duplicated or skipped.

Reset
REQ-025 i_reset=1 SHALL clear both pointers, storage, and o_overflow; after the edge o_valid=0, o_level=0, o_afull=0, o_overflow=0, o_data_out=0.
REQ-026 i_reset SHALL take priority over simultaneous read and write events; words in flight are discarded.
REQ-027 First write accepted SHALL be on the first edge with i_reset=0.

Configuration
REQ-028 Macro COMMON_VALID_ELASTIC_BUFFER_OVF_CNT_EN SHALL, when defined, add output o_ovf_count (16 bits): counts dropped writes per REQ-020, saturates at 16'hFFFF, cleared by i_reset.
REQ-029 When the macro is undefined, o_ovf_count SHALL not exist and no counter logic SHALL be built; all other behaviour identical.

Verification
REQ-030 Reset then single write 8'hA5 at cycle 0, i_ready=1 -> o_valid=1 and o_data_out=8'hA5 at cycle 1; o_valid=0, o_level=0 at cycle 2.
REQ-031 Defaults, i_ready=0, write 0x01..0x08 -> o_level=8, o_afull=1 from the level=6 cycle; 9th write 0x09 -> o_overflow=1, o_ovf_count=1 (macro on); drain -> 0x01..0x08 in order, 0x09 never appears.
REQ-032 Full, i_valid=1 and i_ready=1 together for 20 cycles with incrementing data -> o_level stays 8, o_overflow stays 0, output sequence gap-free across pointer wrap.
REQ-033 Level 4, assert i_reset for one cycle with i_valid=1, i_ready=1 -> next cycle o_valid=0, o_level=0, o_overflow=0; subsequent write 8'h3C emerges first.
REQ-034 Macro on, full, i_ready=0, i_valid=1 for 70000 cycles -> o_ovf_count=16'hFFFF and holds; contents unchanged.
REQ-035 Random i_valid gated by o_afull and random i_ready, 10000 cycles -> scoreboard match, o_overflow=0 throughout.
